// File: rtl/fc_mul_pkg.sv
// Shared definitions for the FactoCore sequential shift-add multiplier:
// state encoding, default sizing and the terminal iteration count.
package fc_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10,
        ST_ILL  = 2'b11
    } fc_mul_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;
    localparam int DEF_TERM_CNT = DEF_WIDTH - 1;

    // Count value on which the last iteration runs, for any operand width.
    function automatic int term_cnt(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/fc_mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// half of the accumulator through a gate-level ripple adder, then shift right.
module fc_mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand_r,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   sum;

    assign hi     = acc[2*WIDTH-1:WIDTH];
    assign addend = mcand_r & {WIDTH{acc[0]}};
    assign prop   = hi ^ addend;
    assign gen    = hi & addend;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        assign sum_bits[i] = prop[i] ^ carry[i];
        assign carry[i+1]  = gen[i] | (prop[i] & carry[i]);
    end

    // Carry-out becomes the new MSB so no product bit is ever lost.
    assign sum      = {carry[WIDTH], sum_bits};
    assign acc_next = {sum, acc[WIDTH-1:1]};

endmodule

// File: rtl/fc_seq_multiplier.sv
// Fixed-latency unsigned shift-add multiplier: one product per start, WIDTH
// iterations, result held in DONE until cleared.
module fc_seq_multiplier
    import fc_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(term_cnt(WIDTH));

    fc_mul_state_e       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [2*WIDTH-1:0]  acc_step;

    fc_mul_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .mcand_r  (mcand_q),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        if (op_clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_start) begin
                        mcand_d = multiplicand;
                        acc_d   = {{WIDTH{1'b0}}, multiplier};
                        cnt_d   = '0;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == TERM_CNT) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state only; no input reaches them directly.
    assign op_done = (state_q == ST_DONE);
    assign result  = op_done ? acc_q : '0;

endmodule

// File: tb/tb_fc_seq_multiplier.sv
// Self-checking bench for fc_seq_multiplier: vector table, random products
// against plain 64-bit multiplication, and hand-written control sequences.
module tb_fc_seq_multiplier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        op_done;
    logic [63:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    fc_seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op_done      (op_done),
        .result       (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
    endtask

    // Starts a product, scrambles the operand inputs every following cycle and
    // optionally re-pulses op_start at cycle inj; returns latency and result.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int inj,
                           output int lat, output logic [63:0] res, output bit leak);
        multiplicand = a;
        multiplier   = b;
        op_start     = 1'b1;
        tick();
        op_start = 1'b0;
        lat  = 0;
        res  = '0;
        leak = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            multiplicand = $urandom;
            multiplier   = $urandom;
            op_start     = (n == inj);
            tick();
            if (op_done) begin
                lat = n;
                res = result;
                break;
            end
            if (result !== 64'd0) leak = 1'b1;
        end
        op_start = 1'b0;
    endtask

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned pa, pb;
        pa = longint'(a);
        pb = longint'(b);
        return 64'(pa * pb);
    endfunction

    initial begin
        int          lat;
        logic [63:0] res;
        bit          leak;
        bit          seen;
        logic [63:0] prod;

        vecs[0] = '{32'd3,          32'd5,          64'd15};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0,          32'h1234_5678,  64'd0};
        vecs[3] = '{32'h1234_5678,  32'd0,          64'd0};
        vecs[4] = '{32'd6,          32'd7,          64'd42};
        vecs[5] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
        vecs[6] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
        vecs[7] = '{32'd65536,      32'd65536,      64'h0000_0001_0000_0000};

        reset_n      = 1'b0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #12;
        check("reset_done", 64'(op_done), 64'd0);
        check("reset_result", result, 64'd0);
        reset_n = 1'b1;
        tick();

        // 3 x 5: exact latency, then result holds while idle inputs wiggle.
        run_mul(32'd3, 32'd5, 0, lat, res, leak);
        check("basic_latency", 64'(lat), 64'd32);
        check("basic_result", res, 64'd15);
        check("basic_no_early_result", 64'(leak), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            op_start = 1'(i % 2);
            tick();
            if (!op_done || result !== 64'd15) seen = 1'b1;
        end
        op_start = 1'b0;
        check("basic_hold", 64'(seen), 64'd0);

        for (int i = 0; i < 8; i++) begin
            do_clear();
            run_mul(vecs[i].a, vecs[i].b, 0, lat, res, leak);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
        end

        // op_start during EXEC with other operands must be ignored.
        do_clear();
        run_mul(32'd11, 32'd13, 10, lat, res, leak);
        check("ignore_start_latency", 64'(lat), 64'd32);
        check("ignore_start_result", res, 64'd143);
        do_clear();
        run_mul(32'd11, 32'd13, 33, lat, res, leak);
        tick();
        tick();
        check("start_in_done_ignored", result, 64'd143);

        // op_clear mid-EXEC aborts to IDLE, then a fresh product works.
        do_clear();
        multiplicand = 32'd100;
        multiplier   = 32'd200;
        op_start     = 1'b1;
        tick();
        op_start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        do_clear();
        check("clear_done", 64'(op_done), 64'd0);
        check("clear_result", result, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (op_done) seen = 1'b1;
        end
        check("clear_stays_idle", 64'(seen), 64'd0);
        run_mul(32'd6, 32'd7, 0, lat, res, leak);
        check("after_clear_latency", 64'(lat), 64'd32);
        check("after_clear_result", res, 64'd42);

        // Asynchronous reset while DONE drops outputs without a clock edge.
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_done", 64'(op_done), 64'd0);
        check("async_rst_result", result, 64'd0);
        #1 reset_n = 1'b1;
        tick();

        // Asynchronous reset mid-EXEC abandons the operation.
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        op_start     = 1'b1;
        tick();
        op_start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        #2 reset_n = 1'b0;
        #1;
        check("exec_rst_done", 64'(op_done), 64'd0);
        check("exec_rst_result", result, 64'd0);
        #2 reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (op_done) seen = 1'b1;
        end
        check("exec_rst_idle", 64'(seen), 64'd0);

        // op_clear wins over op_start in IDLE.
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        op_start     = 1'b1;
        op_clear     = 1'b1;
        tick();
        op_start = 1'b0;
        op_clear = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (op_done || result !== 64'd0) seen = 1'b1;
        end
        check("clear_beats_start", 64'(seen), 64'd0);

        // Factorial chain through the running product's low word.
        prod = 64'd1;
        for (int k = 2; k <= 13; k++) begin
            do_clear();
            run_mul(prod[31:0], 32'(k), 0, lat, res, leak);
            check($sformatf("fact%0d", k), res, model_mul(prod[31:0], 32'(k)));
            prod = res;
            if (k == 12) check("fact12_const", res, 64'd479001600);
            if (k == 13) check("fact13_const", res, 64'd6227020800);
        end

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            do_clear();
            run_mul(ra, rb, (i % 3 == 0) ? int'($urandom_range(1, 31)) : 0, lat, res, leak);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd32);
            check($sformatf("rand%0d_result", i), res, model_mul(ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
